alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Registered front-end stage that feeds the combinational 6-bit mini ALU.
- Accepts operand/function commands over a valid/ready handshake and buffers them in a small FIFO.
- Drives the ALU's A, B and fxn inputs from registers, waits a programmable settle time, then captures the ALU result X.
- Presents the result, tagged with its fxn, on a valid/ready output port.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, at least 2.
- SETTLE_CYCLES, 1, cycles between loading the ALU input registers and capturing X; at least 1, and 0 is illegal.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  command present.
- in_ready  output  1  command accepted when in_valid and in_ready are both high.
- in_a  input  6  operand A.
- in_b  input  6  operand B.
- in_fxn  input  3  ALU function select.
- alu_a  output  6  registered operand A to the ALU.
- alu_b  output  6  registered operand B to the ALU.
- alu_fxn  output  3  registered function select to the ALU.
- alu_x  input  6  combinational ALU result.
- out_valid  output  1  result held.
- out_ready  input  1  consumer accepts the result.
- out_x  output  6  captured result.
- out_fxn  output  3  fxn that produced out_x.
- busy  output  1  high when the FSM is not IDLE or the FIFO is not empty.
- op_count  output  8  completed output handshakes; wraps.

Behaviour:
- Clock and reset:
  - One clock domain.
  - rst is asynchronous and active-high; it is sampled asynchronously and released synchronously by upstream logic.
- Reset values:
  - in_ready=1; alu_a=alu_b=0; alu_fxn=0; out_valid=0; out_x=0; out_fxn=0; busy=0; op_count=0.
  - FIFO is emptied and FSM goes to IDLE.
- Reset mid-operation: all in-flight and buffered commands are discarded; no partial result is emitted.
- FIFO:
  - in_ready = not full.
  - Push on in_valid && in_ready.
  - Pop only on FSM command (see below).
  - A push and a pop in the same cycle leave the occupancy unchanged.
  - No fall-through: a command pushed at edge t is poppable at edge t+1 at the earliest.
  - Pointers wrap modulo DEPTH.
  - An occupancy counter of log2(DEPTH)+1 bits distinguishes full from empty.
- FSM states: IDLE, SETTLE, HOLD.
  - IDLE: if the FIFO is not empty, pop, load alu_a/alu_b/alu_fxn from the head entry, load the settle counter with SETTLE_CYCLES-1, and go to SETTLE.
  - SETTLE: if counter==0, capture out_x<=alu_x and out_fxn<=alu_fxn, set out_valid<=1, and go to HOLD; else decrement the counter.
  - HOLD: out_x and out_fxn are stable while out_valid=1. On out_ready:
    - op_count increments (255 wraps to 0).
    - If the FIFO is not empty: pop, reload the ALU registers, reload the counter, go to SETTLE, and drop out_valid at the same edge.
    - Else: drop out_valid and go to IDLE.
- ALU input registers hold their last value until the next pop; they never glitch during SETTLE or HOLD.
- Latency:
  - Push edge t, pop edge t+1, capture edge t+1+SETTLE_CYCLES.
  - out_valid is visible after that edge: 2 edges when SETTLE_CYCLES=1.
- Throughput: one result per SETTLE_CYCLES+1 cycles when out_ready is held high.
- out_ready while out_valid=0 is ignored.
- in_valid while full is ignored; the upstream must hold the command.

Decomposition:
- Shared package alu_pkg:
  - WORD_W=6, FXN_W=3, CNT_W=8.
  - State enum constants IDLE/SETTLE/HOLD.
  - Command struct layout {a, b, fxn}, 15 bits.
- Sub-module alu_cmd_fifo, parameterised by DEPTH and width 15, with push/pop/full/empty/count.
- The FSM, settle counter, output register and op_count live in the top.

Test Plan:
- Bench ALU model: alu_x = (alu_a + alu_b) mod 64.
- Single command: reset, push a=5, b=9, fxn=3, out_ready=1 -> out_valid rises 2 edges after the push with out_x=14 and out_fxn=3; op_count=1.
- Wrap arithmetic: push a=40, b=30 -> out_x=6.
- Backpressure: out_ready=0, push 5 commands with DEPTH=4 -> the first goes into HOLD and 4 fill the FIFO, so in_ready=0 after the 5th; the 6th is held by upstream. Release out_ready -> 5 results emitted in order with no drops or duplicates.
- Settle time: SETTLE_CYCLES=3, push one command -> out_valid asserted 4 edges after the push; alu_a/alu_b are stable throughout.
- Back-to-back: keep out_ready=1 and stream 300 commands -> one result every 2 cycles after the pipeline fills; op_count reads 300 mod 256 = 44.
- Reset mid-op: assert rst in SETTLE with 2 commands buffered -> all outputs return to reset values immediately; no out_valid follows after release.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, FSM states and command layout for the ALU command sequencer
package alu_pkg;
    localparam int WORD_W = 6;
    localparam int FXN_W  = 3;
    localparam int CNT_W  = 8;
    localparam int CMD_W  = 2 * WORD_W + FXN_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    typedef struct packed {
        logic [WORD_W-1:0] a;
        logic [WORD_W-1:0] b;
        logic [FXN_W-1:0]  fxn;
    } cmd_t;
endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - command FIFO with registered storage and occupancy counter
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - buffers ALU commands, drives the ALU from registers and captures its result
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_a,
    input  logic [WORD_W-1:0] in_b,
    input  logic [FXN_W-1:0]  in_fxn,
    output logic [WORD_W-1:0] alu_a,
    output logic [WORD_W-1:0] alu_b,
    output logic [FXN_W-1:0]  alu_fxn,
    input  logic [WORD_W-1:0] alu_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_x,
    output logic [FXN_W-1:0]  out_fxn,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_CYCLES - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [SCW-1:0]    r_settle_cnt;
    logic [WORD_W-1:0] r_alu_a;
    logic [WORD_W-1:0] r_alu_b;
    logic [FXN_W-1:0]  r_alu_fxn;
    logic [WORD_W-1:0] r_out_x;
    logic [FXN_W-1:0]  r_out_fxn;
    logic [CNT_W-1:0]  r_op_count;
    cmd_t              w_in_cmd;
    cmd_t              w_head;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic              w_push;
    logic              w_pop;
    logic              w_capture;
    logic              w_ack;

    assign w_in_cmd = {in_a, in_b, in_fxn};
    assign w_push   = in_valid && !w_full;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_in_cmd),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        w_ack        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = SETTLE;
                end
            end
            SETTLE: begin
                if (r_settle_cnt == '0) begin
                    w_capture    = 1'b1;
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                // A waiting command is popped on the same edge the result is taken.
                if (out_ready) begin
                    w_ack = 1'b1;
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_next_state = SETTLE;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_fxn    <= '0;
            r_settle_cnt <= '0;
            r_out_x      <= '0;
            r_out_fxn    <= '0;
            r_op_count   <= '0;
        end else begin
            if (w_pop) begin
                r_alu_a      <= w_head.a;
                r_alu_b      <= w_head.b;
                r_alu_fxn    <= w_head.fxn;
                r_settle_cnt <= SETTLE_LOAD;
            end else if (r_state == SETTLE && r_settle_cnt != '0) begin
                r_settle_cnt <= r_settle_cnt - SCW'(1);
            end
            if (w_capture) begin
                r_out_x   <= alu_x;
                r_out_fxn <= r_alu_fxn;
            end
            if (w_ack) begin
                r_op_count <= r_op_count + CNT_W'(1);
            end
        end
    end

    assign in_ready  = !w_full;
    assign out_valid = (r_state == HOLD);
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_fxn   = r_alu_fxn;
    assign out_x     = r_out_x;
    assign out_fxn   = r_out_fxn;
    assign op_count  = r_op_count;
    assign busy      = (r_state != IDLE) || (w_count != '0);
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - self-checking bench for alu_cmd_sequencer against a queue/timestamp model
module tb_alu_cmd_sequencer;
    localparam int DEPTH = 4;
    localparam int S1    = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1 = 1'b1, in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [5:0] in_a1, in_b1, alu_a1, alu_b1, alu_x1, out_x1;
    logic [2:0] in_fxn1, alu_fxn1, out_fxn1;
    logic [7:0] op_count1;

    logic       rst3 = 1'b1, in_valid3, in_ready3, out_valid3, out_ready3, busy3;
    logic [5:0] in_a3, in_b3, alu_a3, alu_b3, alu_x3, out_x3;
    logic [2:0] in_fxn3, alu_fxn3, out_fxn3;
    logic [7:0] op_count3;

    assign alu_x1 = alu_a1 + alu_b1;
    assign alu_x3 = alu_a3 + alu_b3;

    alu_cmd_sequencer #(.DEPTH(DEPTH), .SETTLE_CYCLES(S1)) dut1 (
        .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .in_fxn(in_fxn1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_fxn(alu_fxn1), .alu_x(alu_x1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_x(out_x1), .out_fxn(out_fxn1),
        .busy(busy1), .op_count(op_count1)
    );

    alu_cmd_sequencer #(.DEPTH(DEPTH), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst3), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_a(in_a3), .in_b(in_b3), .in_fxn(in_fxn3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_fxn(alu_fxn3), .alu_x(alu_x3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_x(out_x3), .out_fxn(out_fxn3),
        .busy(busy3), .op_count(op_count3)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: commands wait in a queue stamped with their push edge; one server
    // takes the oldest command no earlier than the edge after its push, exposes
    // its result SETTLE edges later, and frees up on the accepting handshake.
    typedef struct {
        logic [5:0] a;
        logic [5:0] b;
        logic [2:0] f;
        int         t;
    } mcmd_t;

    mcmd_t      q[$];
    mcmd_t      cur;
    int         e        = 0;
    int         m_cap    = 0;
    int         m_cnt    = 0;
    int         hs_n     = 0;
    int         hs_first = 0;
    int         hs_last  = 0;
    bit         m_have   = 1'b0;
    logic [5:0] m_a      = 6'd0;
    logic [5:0] m_b      = 6'd0;
    logic [2:0] m_f      = 3'd0;

    always @(posedge clk or posedge rst1) begin : model_step
        bit    acc;
        mcmd_t n;
        if (rst1) begin
            q.delete();
            m_have = 1'b0;
            m_cnt  = 0;
            hs_n   = 0;
            m_a    = 6'd0;
            m_b    = 6'd0;
            m_f    = 3'd0;
        end else begin
            e++;
            acc = in_valid1 && (q.size() < DEPTH);
            if (m_have && m_cap < e && out_ready1) begin
                m_have = 1'b0;
                m_cnt++;
                if (hs_n == 0) hs_first = e;
                hs_last = e;
                hs_n++;
            end
            if (!m_have && q.size() > 0 && q[0].t < e) begin
                cur    = q.pop_front();
                m_have = 1'b1;
                m_cap  = e + S1;
                m_a    = cur.a;
                m_b    = cur.b;
                m_f    = cur.f;
            end
            if (acc) begin
                n.a = in_a1;
                n.b = in_b1;
                n.f = in_fxn1;
                n.t = e;
                q.push_back(n);
            end
        end
    end

    always @(negedge clk) begin : compare
        bit         ev;
        logic [5:0] ex;
        if (chk_on) begin
            ev = m_have && (m_cap <= e);
            ex = cur.a + cur.b;
            chk("out_valid", 32'(out_valid1), 32'(ev));
            chk("in_ready", 32'(in_ready1), 32'(q.size() < DEPTH));
            chk("busy", 32'(busy1), 32'(m_have || q.size() > 0));
            chk("op_count", 32'(op_count1), 32'(m_cnt % 256));
            chk("alu_a", 32'(alu_a1), 32'(m_a));
            chk("alu_b", 32'(alu_b1), 32'(m_b));
            chk("alu_fxn", 32'(alu_fxn1), 32'(m_f));
            if (ev) begin
                chk("out_x", 32'(out_x1), 32'(ex));
                chk("out_fxn", 32'(out_fxn1), 32'(cur.f));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send1(input logic [5:0] a, input logic [5:0] b, input logic [2:0] f);
        int g = 0;
        in_valid1 = 1'b1;
        in_a1     = a;
        in_b1     = b;
        in_fxn1   = f;
        while (!in_ready1 && g < 500) begin
            step();
            g++;
        end
        if (g >= 500) begin
            checks++;
            failures++;
            $display("FAIL send1_timeout: in_ready stayed %0d, required 1", in_ready1);
        end
        step();
        in_valid1 = 1'b0;
    endtask

    task automatic wait_idle1(input int bound);
        int g = 0;
        while ((busy1 || out_valid1) && g < bound) begin
            step();
            g++;
        end
        if (g >= bound) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: busy=%0d out_valid=%0d, required 0", busy1, out_valid1);
        end
    endtask

    task automatic wait_valid1(input int bound);
        int g = 0;
        while (!out_valid1 && g < bound) begin
            step();
            g++;
        end
        if (g >= bound) begin
            checks++;
            failures++;
            $display("FAIL valid_timeout: out_valid=%0d, required 1", out_valid1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int  seen;
        bit  pr;
        in_valid1 = 0; in_a1 = 0; in_b1 = 0; in_fxn1 = 0; out_ready1 = 0;
        in_valid3 = 0; in_a3 = 0; in_b3 = 0; in_fxn3 = 0; out_ready3 = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_in_ready", 32'(in_ready1), 32'd1);
        chk("rst_out_valid", 32'(out_valid1), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_op_count", 32'(op_count1), 32'd0);
        chk("rst_alu_a", 32'(alu_a1), 32'd0);
        chk("rst_out_x", 32'(out_x1), 32'd0);
        rst1 = 1'b0;
        rst3 = 1'b0;
        chk_on = 1'b1;

        out_ready1 = 1'b1;
        send1(6'd5, 6'd9, 3'd3);
        step();
        chk("single_not_yet", 32'(out_valid1), 32'd0);
        step();
        chk("single_valid", 32'(out_valid1), 32'd1);
        chk("single_x", 32'(out_x1), 32'd14);
        chk("single_fxn", 32'(out_fxn1), 32'd3);
        step();
        chk("single_count", 32'(op_count1), 32'd1);

        send1(6'd40, 6'd30, 3'd1);
        wait_valid1(20);
        chk("wrap_x", 32'(out_x1), 32'd6);
        wait_idle1(20);

        out_ready1 = 1'b0;
        for (int i = 0; i < 5; i++) send1(6'(10 + i), 6'(i), 3'(i));
        chk("bp_full", 32'(in_ready1), 32'd0);
        in_valid1 = 1'b1; in_a1 = 6'd50; in_b1 = 6'd13; in_fxn1 = 3'd7;
        repeat (5) step();
        chk("bp_still_full", 32'(in_ready1), 32'd0);
        chk("bp_head_x", 32'(out_x1), 32'd10);
        out_ready1 = 1'b1;
        send1(6'd50, 6'd13, 3'd7);
        wait_idle1(100);
        chk("bp_count", 32'(op_count1), 32'd8);

        rst1 = 1'b1;
        step();
        rst1 = 1'b0;
        for (int i = 0; i < 300; i++) send1(6'($urandom), 6'($urandom), 3'($urandom));
        wait_idle1(2000);
        chk("stream_count", 32'(op_count1), 32'd44);
        chk("stream_model_hs", 32'(hs_n), 32'd300);
        chk("stream_rate", 32'(hs_last - hs_first), 32'd598);

        for (int c = 0; c < 3000; c++) begin
            if (!(in_valid1 && !pr)) begin
                in_valid1 = ($urandom % 4) != 0;
                in_a1     = 6'($urandom);
                in_b1     = 6'($urandom);
                in_fxn1   = 3'($urandom);
            end
            out_ready1 = ($urandom % 3) != 0;
            pr = in_ready1;
            step();
        end
        in_valid1  = 1'b0;
        out_ready1 = 1'b1;
        wait_idle1(100);

        out_ready3 = 1'b1;
        in_valid3 = 1'b1; in_a3 = 6'd7; in_b3 = 6'd20; in_fxn3 = 3'd5;
        step();
        in_valid3 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("settle_wait", 32'(out_valid3), 32'd0);
            chk("settle_a", 32'(alu_a3), 32'd7);
            chk("settle_b", 32'(alu_b3), 32'd20);
        end
        step();
        chk("settle_valid", 32'(out_valid3), 32'd1);
        chk("settle_x", 32'(out_x3), 32'd27);
        chk("settle_fxn", 32'(out_fxn3), 32'd5);
        step();
        chk("settle_count", 32'(op_count3), 32'd1);

        out_ready3 = 1'b0;
        in_valid3 = 1'b1; in_a3 = 6'd1; in_b3 = 6'd2; in_fxn3 = 3'd1;
        step();
        in_a3 = 6'd3; in_b3 = 6'd4; in_fxn3 = 3'd2;
        step();
        in_a3 = 6'd5; in_b3 = 6'd6; in_fxn3 = 3'd3;
        step();
        in_valid3 = 1'b0;
        chk("midop_busy", 32'(busy3), 32'd1);
        chk("midop_alu_a", 32'(alu_a3), 32'd1);
        chk("midop_settling", 32'(out_valid3), 32'd0);
        rst3 = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready3), 32'd1);
        chk("midrst_busy", 32'(busy3), 32'd0);
        chk("midrst_alu", 32'({alu_a3, alu_b3, alu_fxn3}), 32'd0);
        chk("midrst_out", 32'({out_x3, out_fxn3}), 32'd0);
        chk("midrst_count", 32'(op_count3), 32'd0);
        out_ready3 = 1'b1;
        step();
        rst3 = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (out_valid3 || busy3) seen++;
        end
        chk("midrst_no_output", 32'(seen), 32'd0);

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
